// File: rtl/ram_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ram_frame_ctrl
//   Store-and-forward controller in front of a 64x8 single-port RAM. It
//   accepts one frame of bytes on a valid/ready input stream and writes it to
//   RAM addresses 0..N-1. It then reads the frame back in order and presents
//   it on a valid/ready output stream. When the last byte is handed off, it
//   returns to accepting the next frame.
//
// Ports
//   clk        in   rising-edge clock, shared with the RAM
//   rst_n      in   asynchronous active-low reset
//   s_data     in   input byte
//   s_valid    in   input byte valid
//   s_last     in   input byte is the last byte of its frame
//   s_ready    out  controller accepts an input byte (only while filling)
//   m_data     out  output byte (registered)
//   m_valid    out  output byte valid (registered)
//   m_last     out  output byte is the last byte of its frame (registered)
//   m_ready    in   downstream accepts the output byte
//   ram_ip     out  RAM write data (mirrors s_data)
//   ram_add    out  RAM address
//   ram_wr     out  RAM write enable; when low, the RAM registers ram_add
//   ram_q      in   RAM read data, valid one cycle after the read address
//   frame_len  out  length of the most recently stored frame, 1..DEPTH
//   trunc      out  pulse: frame forced to end at DEPTH bytes without s_last
// ---------------------------------------------------------------------------
module ram_frame_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic [DATA_W-1:0] ram_ip,
   output logic [ADDR_W-1:0] ram_add,
   output logic              ram_wr,
   input  logic [DATA_W-1:0] ram_q,
   output logic [ADDR_W:0]   frame_len,
   output logic              trunc
);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_wptr;
   logic [ADDR_W-1:0]   r_rptr;
   logic [ADDR_W:0]     r_frame_len;
   logic [DATA_W-1:0]   r_m_data;
   logic                r_m_valid;
   logic                r_m_last;

   logic                w_fill;
   logic                w_accept;
   logic                w_at_end;
   logic                w_rd_last;

   assign w_fill    = (r_state == FILL);
   assign w_accept  = w_fill && s_valid;
   // Write pointer sits on the final RAM location; the frame must end here.
   assign w_at_end  = (r_wptr == ADDR_W'(DEPTH - 1));
   // Read pointer is on the final stored byte of the frame.
   assign w_rd_last = ({1'b0, r_rptr} == (r_frame_len - 1'b1));

   // The RAM port is shared: write address while filling, read address after.
   assign s_ready   = w_fill;
   assign ram_ip    = s_data;
   assign ram_wr    = w_accept;
   assign ram_add   = w_fill ? r_wptr : r_rptr;
   // Truncation is flagged in the cycle the 64th byte is accepted without s_last.
   assign trunc     = w_accept && w_at_end && !s_last;

   assign m_data    = r_m_data;
   assign m_valid   = r_m_valid;
   assign m_last    = r_m_last;
   assign frame_len = r_frame_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_frame_len <= '0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (s_valid) begin
                  // Wraps to 0 after the final location, but the frame ends there anyway.
                  r_wptr <= r_wptr + 1'b1;
                  if (s_last || w_at_end) begin
                     r_frame_len <= {1'b0, r_wptr} + 1'b1;
                     r_rptr      <= '0;
                     r_state     <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               // RAM latches ram_add=rptr at this edge.
               r_state <= RD_DATA;
            end
            RD_DATA: begin
               r_m_data  <= ram_q;
               r_m_last  <= w_rd_last;
               r_m_valid <= 1'b1;
               r_state   <= OUT;
            end
            OUT: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  if (r_m_last) begin
                     r_wptr  <= '0;
                     r_state <= FILL;
                  end else begin
                     r_rptr  <= r_rptr + 1'b1;
                     r_state <= RD_ADDR;
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_frame_ctrl.sv
module tb_ram_frame_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;
   logic [7:0] ram_ip;
   logic [5:0] ram_add;
   logic       ram_wr;
   logic [7:0] ram_q;
   logic [6:0] frame_len;
   logic       trunc;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic [6:0] fl;
   } exp_t;

   exp_t sb[$];

   ram_frame_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .ram_ip(ram_ip), .ram_add(ram_add), .ram_wr(ram_wr), .ram_q(ram_q),
      .frame_len(frame_len), .trunc(trunc)
   );

   // 64x8 single-port RAM: write when ram_wr, else register read data.
   logic [7:0] mem [64];
   logic [7:0] r_q;
   assign ram_q = r_q;
   always @(posedge clk) begin
      if (ram_wr) mem[ram_add] <= ram_ip;
      else        r_q <= mem[ram_add];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake, checks stall stability.
   logic       stall_prev = 1'b0;
   logic [7:0] prev_d;
   logic       prev_l;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (ram_wr) check("ram_wr_outside_fill", 32'(s_ready), 32'd1);
            if (m_valid) begin
               check("s_ready_in_readback", 32'(s_ready), 32'd0);
               if (stall_prev) begin
                  check("stall_data_stable", 32'(m_data), 32'(prev_d));
                  check("stall_last_stable", 32'(m_last), 32'(prev_l));
               end
            end
            if (m_valid && m_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", 32'(m_data), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  check("m_data", 32'(m_data), 32'(e.d));
                  check("m_last", 32'(m_last), 32'(e.l));
                  check("frame_len", 32'(frame_len), 32'(e.fl));
               end
            end
            stall_prev = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
         end
      end
   end

   // Offer one byte, wait (bounded) for acceptance, push its expected output.
   task automatic send_byte(input logic [7:0] d, input logic sl, input logic el,
                            input logic et, input logic [6:0] fl, input logic chk_empty);
      int cnt;
      exp_t e;
      s_data  = d;
      s_last  = sl;
      s_valid = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!s_ready && cnt < 600) begin
         @(negedge clk);
         cnt++;
      end
      if (!s_ready) begin
         errors++;
         checks++;
         $display("FAIL s_ready_timeout: got 0 expected 1 at %0t", $time);
      end
      check("trunc", 32'(trunc), 32'(et));
      if (chk_empty) check("prev_frame_drained", 32'(sb.size()), 32'd0);
      e.d  = d;
      e.l  = el;
      e.fl = fl;
      sb.push_back(e);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!(sb.size() == 0 && s_ready && !m_valid) && cnt < 800) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 800) begin
         errors++;
         checks++;
         $display("FAIL drain_timeout: got pending=%0d expected 0 at %0t", sb.size(), $time);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n   = 1'b0;
      s_data  = 8'h00;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_frame_len", 32'(frame_len), 32'd0);
      check("rst_trunc", 32'(trunc), 32'd0);
      check("rst_ram_wr", 32'(ram_wr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: four-byte frame
      send_byte(8'h11, 1'b0, 1'b0, 1'b0, 7'd4, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0, 1'b0, 7'd4, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0, 1'b0, 7'd4, 1'b0);
      send_byte(8'h44, 1'b1, 1'b1, 1'b0, 7'd4, 1'b0);
      wait_drain();

      // 2: single byte, latency and return to FILL
      send_byte(8'hA5, 1'b1, 1'b1, 1'b0, 7'd1, 1'b0);
      @(negedge clk);
      check("lat_rd_addr_m_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("lat_rd_data_m_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("lat_out_m_valid", 32'(m_valid), 32'd1);
      check("lat_out_m_data", 32'(m_data), 32'hA5);
      check("lat_out_m_last", 32'(m_last), 32'd1);
      @(negedge clk);
      check("back_to_fill_s_ready", 32'(s_ready), 32'd1);
      check("back_to_fill_m_valid", 32'(m_valid), 32'd0);
      wait_drain();

      // 3: 64 bytes without s_last -> truncation
      for (int i = 0; i < 64; i++)
         send_byte(8'(i), 1'b0, (i == 63), (i == 63), 7'd64, 1'b0);
      wait_drain();

      // 4: three-byte frame, five-cycle stall on byte 2
      m_ready = 1'b0;
      send_byte(8'h5A, 1'b0, 1'b0, 1'b0, 7'd3, 1'b0);
      send_byte(8'h6B, 1'b0, 1'b0, 1'b0, 7'd3, 1'b0);
      send_byte(8'h7C, 1'b1, 1'b1, 1'b0, 7'd3, 1'b0);
      for (int b = 0; b < 3; b++) begin
         int cnt;
         cnt = 0;
         while (!m_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
         end
         check("stall_m_valid_seen", 32'(m_valid), 32'd1);
         if (b == 2) begin
            repeat (5) begin
               @(posedge clk);
               #1;
            end
         end
         m_ready = 1'b1;
         @(posedge clk);
         #1;
         m_ready = 1'b0;
      end
      m_ready = 1'b1;
      wait_drain();

      // 5: reset in the middle of a 20-byte frame
      for (int i = 0; i < 10; i++)
         send_byte(8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, 7'd20, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_m_data", 32'(m_data), 32'd0);
      check("midrst_m_last", 32'(m_last), 32'd0);
      check("midrst_frame_len", 32'(frame_len), 32'd0);
      check("midrst_s_ready", 32'(s_ready), 32'd1);
      check("midrst_ram_wr", 32'(ram_wr), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      send_byte(8'hC1, 1'b0, 1'b0, 1'b0, 7'd2, 1'b0);
      send_byte(8'hC2, 1'b1, 1'b1, 1'b0, 7'd2, 1'b0);
      wait_drain();

      // 6: back-to-back frames of 5 and 2 bytes
      for (int i = 0; i < 5; i++)
         send_byte(8'hD0 + 8'(i), (i == 4), (i == 4), 1'b0, 7'd5, 1'b0);
      send_byte(8'hE0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1);
      send_byte(8'hE1, 1'b1, 1'b1, 1'b0, 7'd2, 1'b0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
